// File: rtl/decode_stage_if.sv
// Handshake bundle between Fetch, the decode stage and rename/issue.
// The slave modport is the decode stage's view; master is the surrounding pipeline's.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_reg_write;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_fmt, out_imm, out_reg_write, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_fmt, out_imm, out_reg_write, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes at accept into a main output register backed by
// a one-entry skid register, so in_ready never depends combinationally on out_ready.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            illegal;
  } dec_t;

  dec_t             w_dec;
  dec_t             r_main;
  dec_t             r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_deq;
  logic [XLEN-1:0]  w_ins;

  assign w_ins = bus.in_instr;

  always_comb begin
    w_dec        = '0;
    w_dec.pc     = bus.in_pc;
    w_dec.opcode = w_ins[6:0];
    w_dec.rd     = w_ins[11:7];
    w_dec.rs1    = w_ins[19:15];
    w_dec.rs2    = w_ins[24:20];
    w_dec.funct3 = w_ins[14:12];
    w_dec.funct7 = w_ins[31:25];
    case (w_ins[6:0])
      7'b0110011:                         w_dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: w_dec.fmt = FMT_I;
      7'b0100011:                         w_dec.fmt = FMT_S;
      7'b1100011:                         w_dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:             w_dec.fmt = FMT_U;
      7'b1101111:                         w_dec.fmt = FMT_J;
      default:                            w_dec.fmt = FMT_NONE;
    endcase
    // The all-zero word is Fetch's end marker, not a real instruction.
    if (w_ins == '0) w_dec.fmt = FMT_NONE;
    case (w_dec.fmt)
      FMT_I: w_dec.imm = {{(XLEN-12){w_ins[31]}}, w_ins[31:20]};
      FMT_S: w_dec.imm = {{(XLEN-12){w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      FMT_B: w_dec.imm = {{(XLEN-13){w_ins[31]}}, w_ins[31], w_ins[7],
                          w_ins[30:25], w_ins[11:8], 1'b0};
      FMT_U: w_dec.imm = {w_ins[31:12], 12'b0};
      FMT_J: w_dec.imm = {{(XLEN-21){w_ins[31]}}, w_ins[31], w_ins[19:12],
                          w_ins[20], w_ins[30:21], 1'b0};
      default: w_dec.imm = '0;
    endcase
    w_dec.illegal = (w_dec.fmt == FMT_NONE);
    if (w_dec.fmt == FMT_S || w_dec.fmt == FMT_B) w_dec.rd = 5'd0;
    w_dec.reg_write = (w_dec.fmt == FMT_R || w_dec.fmt == FMT_I ||
                       w_dec.fmt == FMT_U || w_dec.fmt == FMT_J) && (w_dec.rd != 5'd0);
  end

  assign w_accept = bus.in_valid && !r_skid_valid && !flush && !reset;
  assign w_deq    = r_main_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_main.fmt   <= FMT_NONE;
      r_skid       <= '0;
      r_count      <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_accept) r_count <= r_count + CNT_W'(1);
      if (!r_main_valid) begin
        if (w_accept) begin
          r_main       <= w_dec;
          r_main_valid <= 1'b1;
        end
      end else if (w_deq) begin
        // Skid drains first to preserve order; it cannot accept while full.
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main <= w_dec;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready      = !r_skid_valid;
  assign bus.out_valid     = r_main_valid;
  assign bus.out_pc        = r_main.pc;
  assign bus.out_opcode    = r_main.opcode;
  assign bus.out_rd        = r_main.rd;
  assign bus.out_rs1       = r_main.rs1;
  assign bus.out_rs2       = r_main.rs2;
  assign bus.out_funct3    = r_main.funct3;
  assign bus.out_funct7    = r_main.funct7;
  assign bus.out_fmt       = r_main.fmt;
  assign bus.out_imm       = r_main.imm;
  assign bus.out_reg_write = r_main.reg_write;
  assign bus.out_illegal   = r_main.illegal;
  assign instr_count       = r_count;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage, checked against a queue-based
// model of the stage occupancy and an arithmetic model of RV32I decoding.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] instr_count;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_cnt = 0;
  logic [31:0] next_pc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_instr = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Format and immediate derived from the ISA tables with integer arithmetic.
  function automatic void ref_decode(input logic [31:0] w, output logic [2:0] fmt,
                                     output logic [31:0] imm);
    int s;
    s = $signed(w);
    case (w[6:0])
      7'h33:               fmt = 3'd0;
      7'h13, 7'h03, 7'h67: fmt = 3'd1;
      7'h23:               fmt = 3'd2;
      7'h63:               fmt = 3'd3;
      7'h37, 7'h17:        fmt = 3'd4;
      7'h6F:               fmt = 3'd5;
      default:             fmt = 3'd7;
    endcase
    if (w == 32'd0) fmt = 3'd7;
    case (fmt)
      3'd1: imm = 32'(s >>> 20);
      3'd2: imm = 32'((s >>> 25) << 5) | 32'(w[11:7]);
      3'd3: imm = 32'((s >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                  | (32'(w[11:8]) << 1);
      3'd4: imm = w & 32'hFFFFF000;
      3'd5: imm = 32'((s >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                  | (32'(w[30:21]) << 1);
      default: imm = 32'd0;
    endcase
  endfunction

  task automatic check_outputs();
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] w;
    logic [4:0]  rd;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("instr_count", instr_count, m_cnt);
    if (q.size() > 0) begin
      w = q[0].instr;
      ref_decode(w, fmt, imm);
      rd = (fmt == 3'd2 || fmt == 3'd3) ? 5'd0 : w[11:7];
      chk("pc", bus.out_pc, q[0].pc);
      chk("opcode", 32'(bus.out_opcode), 32'(w[6:0]));
      chk("rd", 32'(bus.out_rd), 32'(rd));
      chk("rs1", 32'(bus.out_rs1), 32'(w[19:15]));
      chk("rs2", 32'(bus.out_rs2), 32'(w[24:20]));
      chk("funct3", 32'(bus.out_funct3), 32'(w[14:12]));
      chk("funct7", 32'(bus.out_funct7), 32'(w[31:25]));
      chk("fmt", 32'(bus.out_fmt), 32'(fmt));
      chk("imm", bus.out_imm, imm);
      chk("reg_write", 32'(bus.out_reg_write),
          32'((fmt == 3'd0 || fmt == 3'd1 || fmt == 3'd4 || fmt == 3'd5) && rd != 5'd0));
      chk("illegal", 32'(bus.out_illegal), 32'(fmt == 3'd7));
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // check at the next falling edge. A refused input is re-presented unchanged.
  task automatic step(input logic v, input logic [31:0] w, input logic ordy,
                      input logic fl, input logic rst);
    logic acc;
    logic deq;
    if (pend) begin
      v = 1'b1;
      w = pend_instr;
    end
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = next_pc;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rst;
    acc = v && (q.size() < 2) && !fl && !rst;
    deq = (q.size() > 0) && ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt   = 0;
      next_pc = 0;
      pend    = 1'b0;
    end else if (fl) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) begin
        q.push_back('{pc: next_pc, instr: w});
        m_cnt++;
        next_pc += 4;
      end
      pend       = v && !acc;
      pend_instr = w;
    end
    @(negedge clk);
    $display("cyc v=%0b instr=%h ordy=%0b flush=%0b rst=%0b acc=%0b occ=%0d",
             v, w, ordy, fl, rst, acc, q.size());
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h7F};
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 19) == 0) return 32'd0;
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  logic [31:0] saved_cnt;
  int          accepted;
  int          cyc;
  logic        ordy_tab[10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.in_pc     = 32'd0;
    bus.out_ready = 1'b0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_fmt", 32'(bus.out_fmt), 32'd7);
    chk("rst_imm", bus.out_imm, 32'd0);

    // Directed decode cases, one in flight at a time.
    step(1, 32'h003100B3, 1, 0, 0);
    chk("add_fmt", 32'(bus.out_fmt), 32'd0);
    chk("add_rd", 32'(bus.out_rd), 32'd1);
    chk("add_rs1", 32'(bus.out_rs1), 32'd2);
    chk("add_rs2", 32'(bus.out_rs2), 32'd3);
    chk("add_regw", 32'(bus.out_reg_write), 32'd1);
    step(1, 32'hFFF00293, 1, 0, 0);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(bus.out_rd), 32'd5);
    step(1, 32'h0020A423, 1, 0, 0);
    chk("sw_imm", bus.out_imm, 32'h00000008);
    chk("sw_rd", 32'(bus.out_rd), 32'd0);
    chk("sw_regw", 32'(bus.out_reg_write), 32'd0);
    step(1, 32'hFE000EE3, 1, 0, 0);
    chk("beq_fmt", 32'(bus.out_fmt), 32'd3);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    step(1, 32'h00000000, 1, 0, 0);
    chk("zero_ill", 32'(bus.out_illegal), 32'd1);
    chk("zero_fmt", 32'(bus.out_fmt), 32'd7);
    step(1, 32'h0000007F, 1, 0, 0);
    chk("op7f_ill", 32'(bus.out_illegal), 32'd1);
    chk("op7f_imm", bus.out_imm, 32'd0);
    step(0, 0, 1, 0, 0);

    // Six-instruction stream with back-pressure on cycles 2-4.
    step(0, 0, 0, 0, 1);
    accepted = 0;
    cyc = 0;
    while (accepted < 6 && cyc < 10) begin
      saved_cnt = m_cnt;
      step(1, 32'h00000013 | (32'(cyc) << 7), ordy_tab[cyc], 0, 0);
      if (m_cnt != saved_cnt) accepted++;
      if (cyc == 3) chk("stream_stall_ready", 32'(bus.in_ready), 32'd0);
      cyc++;
    end
    chk("stream_accepts", 32'(accepted), 32'd6);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("stream_count", instr_count, 32'd6);
    chk("stream_drained", 32'(bus.out_valid), 32'd0);

    // Flush with two buffered and a new input in the same cycle.
    step(1, rand_instr(), 0, 0, 0);
    step(1, rand_instr(), 0, 0, 0);
    saved_cnt = instr_count;
    step(1, 32'h00500093, 0, 1, 0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_count", instr_count, saved_cnt);
    step(0, 0, 1, 0, 0);
    chk("flush_no_leak", 32'(bus.out_valid), 32'd0);

    // Reset while both entries are full.
    step(1, rand_instr(), 0, 0, 0);
    step(1, rand_instr(), 0, 0, 0);
    step(1, rand_instr(), 0, 0, 1);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_count", instr_count, 32'd0);
    chk("rst_mid_fmt", 32'(bus.out_fmt), 32'd7);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Stage directly downstream of Fetch.
- Accepts one fetched RV32I instruction and its PC per cycle over a valid/ready handshake, and decodes the fields, format and sign-extended immediate.
- Presents the result from registered outputs to the next stage (rename/issue).
- A 2-entry skid buffer absorbs back-pressure without dropping or reordering instructions. Flush and reset empty it.

Parameters:
- XLEN, 32, datapath width for PC, instruction and immediate.
- CNT_W, 32, width of the accepted-instruction counter.

Ports:
- clk  in  1  clock. One clock domain; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  XLEN  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream consumes the instruction this cycle.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_opcode  out  7  instr[6:0].
- out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7] / [19:15] / [24:20].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_imm  out  XLEN  sign-extended immediate.
- out_reg_write  out  1  instruction writes a nonzero rd.
- out_illegal  out  1  unsupported opcode or all-zero word.
- instr_count  out  CNT_W  number of instructions accepted since reset.

Behaviour:
- Handshakes:
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - Producers hold their data stable while valid is high and ready is low.
- Storage:
  - Main register drives the out_* signals; a skid register sits behind it.
  - in_ready = !skid_valid, taken from a register (no combinational path from out_ready).
- Decode is combinational on in_instr and is captured at accept.
  - Latency is 1 cycle: accepted at edge N, out_valid high after edge N.
- Enqueue/dequeue in the same cycle:
  - Main full and skid empty: main is refilled; throughput is 1 per cycle.
  - Accept with main full and not consumed: the entry goes to skid.
  - Dequeue with skid full: skid moves to main; in_ready rises next cycle.
- Ordering is strictly FIFO; no instruction is lost or duplicated.
- Opcode to format mapping:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else, or in_instr == 0 -> NONE with out_illegal=1, out_imm=0, out_reg_write=0. The all-zero word is Fetch's end marker.
- Immediates (all sign-extended from instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0} (no extension needed).
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: out_imm = 0.
- Register fields:
  - out_reg_write = fmt in {R, I, U, J} && rd != 0.
  - For S and B, out_rd is forced to 0.
  - Field extraction is raw regardless of format; no other masking.
- instr_count:
  - Increments by 1 per accepted input.
  - Wraps modulo 2^CNT_W.
  - Unaffected by flush; cleared only by reset.
- Reset:
  - out_valid=0, skid empty, in_ready=1 after the edge.
  - All out_* data = 0, out_fmt=7, instr_count=0.
  - Reset while holding instructions drops them.
- Flush:
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An input presented in the flush cycle is not accepted and is not counted.
  - reset has priority over flush.
- in_ready during reset/flush cycles follows the registered state, but acceptance is suppressed.

Test Plan:
- add x1,x2,x3 (in_instr=0x003100B3, pc=0x0) -> next cycle out_valid=1, fmt=0, rd=1, rs1=2, rs2=3, funct3=0, funct7=0, imm=0, reg_write=1.
- addi x5,x0,-1 (0xFFF00293) -> fmt=1, rd=5, imm=0xFFFFFFFF, reg_write=1. sw x2,8(x1) (0x0020A423) -> fmt=2, rd=0, rs1=1, rs2=2, imm=0x00000008, reg_write=0.
- beq x0,x0,-4 (0xFE000EE3) -> fmt=3, imm=0xFFFFFFFC. Words 0x00000000 and 0x0000007F -> out_illegal=1, fmt=7, imm=0, reg_write=0.
- Stream 6 instructions with in_valid=1; hold out_ready=0 for cycles 2-4 -> in_ready=0 after 2 accepts; once out_ready=1, all 6 exit in order with PCs 0,4,...,20; instr_count=6.
- With 2 instructions buffered, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears; instr_count unchanged.
- Assert reset mid-stream with both entries full -> after the edge out_valid=0, in_ready=1, instr_count=0, out_fmt=7.
